fifomult_operand_feeder: RTL and testbench
==========================================

Name: fifomult_operand_feeder

Overview:
- Upstream stage of the fifomult2024 multiplier.
- Accepts operand pairs (A, B) from a producer over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each pair onto the multiplier's single-word input bus as two consecutive valid words, A then B, each with even parity.
- Honours the multiplier's busy_out back-pressure and supports per-word parity-error injection, so the multiplier's data_in_parity_error path can be exercised.

Parameters:
- DATA_W, 16: operand word width; matches the multiplier data_in width.
- DEPTH, 4: FIFO depth in operand pairs; power of two, at least 2.
- GAP_CYCLES, 1: idle cycles forced on data_out_valid after each B word; at least 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  producer offers a pair.
- s_ready  out  1  feeder can accept a pair; equals !full, combinational.
- s_a  in  DATA_W  operand A.
- s_b  in  DATA_W  operand B.
- s_err_a  in  1  invert the parity sent with A.
- s_err_b  in  1  invert the parity sent with B.
- busy_in  in  1  connected to the multiplier busy_out.
- data_out  out  DATA_W  word to the multiplier data_in.
- data_out_parity  out  1  to the multiplier data_in_parity.
- data_out_valid  out  1  to the multiplier data_in_valid.
- level  out  $clog2(DEPTH+1)  number of pairs currently stored.
- pairs_sent  out  16  count of completed pairs; wraps modulo 2^16.

Behaviour:
- Reset: async, active-high. Clears FIFO pointers, level, pairs_sent, data_out, data_out_parity and data_out_valid to 0, and sets state to IDLE. s_ready reads 1 after reset.
- Reset mid-transfer: valid drops immediately and the partially sent pair is discarded. The next pair sent after reset always starts with A.
- Push: on a rising edge where s_valid && s_ready, {s_a, s_b, s_err_a, s_err_b} is written at the write pointer and level increments.
- Full: when level == DEPTH, s_ready = 0 and s_valid is ignored. There is no write-through, even in a cycle where a pop also occurs.
- Pointers wrap modulo DEPTH.
- Parity: data_out_parity = (^word) XOR err_flag. With err_flag = 0 this is even parity: the total count of ones across word and parity bit is even.
- All data_out* outputs are registered.
- FSM states and transitions:
  - IDLE: if level != 0 and busy_in == 0 at the edge, load the head entry's A and its parity, set valid = 1, go to SEND_A. Otherwise valid = 0 and the state holds.
  - SEND_A: the next edge unconditionally drives B and its parity, valid = 1, and goes to SEND_B. busy_in is not re-sampled between A and B.
  - SEND_B: the next edge pops the head entry (level decrements), increments pairs_sent, sets valid = 0, and goes to GAP.
  - GAP: holds valid = 0 for GAP_CYCLES edges in total, counted from the SEND_B exit, then returns to IDLE.
- Simultaneous push and pop on the same edge: level is unchanged and both pointers advance.
- data_out holds its last value while valid = 0. Consumers must not rely on that value.
- Latency (empty FIFO, busy_in low, GAP_CYCLES = 1):
  - Pair accepted at edge k.
  - A is valid after edge k+1.
  - B is valid after edge k+2.
  - valid is low after edge k+3.
  - The next pair's A is valid after edge k+4.
- Steady-state throughput: one pair per 2 + GAP_CYCLES cycles.
- Back-pressure: when busy_in rises while in IDLE, issue stalls and the FIFO keeps filling. When busy_in rises during SEND_A, B is still sent.
- No combinational path from busy_in to any output.

Test Plan:
1. Reset: assert rst mid-cycle with valid = 1 during SEND_A → data_out_valid = 0 immediately, level = 0, pairs_sent = 0, s_ready = 1. After release, push one pair (A = 16'h0001, B = 16'h0003) → both words appear with A first.
2. Single pair, A = 16'h00F1, B = 16'h8000, no error → data_out = 16'h00F1 with parity 1 after edge k+1, then 16'h8000 with parity 1 after edge k+2, valid low at k+3, pairs_sent = 1.
3. Error injection: A = 16'h0000 with s_err_a = 1, B = 16'hFFFF with s_err_b = 0 → A parity bit 1, B parity bit 0.
4. Full FIFO: hold busy_in = 1 and push 5 pairs back-to-back → first 4 accepted, level = 4, s_ready = 0, 5th held off. Drop busy_in → 4 pairs emitted in push order, each as A then B, 3 cycles apart. The 5th pair is accepted on the cycle after the first pop.
5. Busy during transfer: raise busy_in in the SEND_A cycle → B still follows. No new A is issued until busy_in = 0 is sampled in IDLE.
6. Wrap: stream 20 random pairs with random busy_in stalls → output order matches input order, pairs_sent = 20, and each word's parity is even.

Source files
------------

// File: rtl/fifomult_operand_feeder.sv
// Operand feeder for the fifomult2024 multiplier: buffers (A,B) pairs and
// serialises each pair as two valid words (A then B) with even parity.
module fifomult_operand_feeder #(
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_W-1:0]            s_a,
  input  logic [DATA_W-1:0]            s_b,
  input  logic                         s_err_a,
  input  logic                         s_err_b,
  input  logic                         busy_in,
  output logic [DATA_W-1:0]            data_out,
  output logic                         data_out_parity,
  output logic                         data_out_valid,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [15:0]                  pairs_sent
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES - 1) : 1;

  typedef enum logic [1:0] {IDLE, SEND_A, SEND_B, GAP} state_t;

  logic [DATA_W-1:0] memA [DEPTH];
  logic [DATA_W-1:0] memB [DEPTH];
  logic              memErrA [DEPTH];
  logic              memErrB [DEPTH];

  state_t            state_q;
  logic [PW-1:0]     wrPtr_q, rdPtr_q;
  logic [LW-1:0]     level_q, level_d;
  logic [GW-1:0]     gapCnt_q;
  logic [15:0]       pairsSent_q;
  logic [DATA_W-1:0] dataOut_q;
  logic              parity_q;
  logic              valid_q;

  logic push, pop;
  logic [DATA_W-1:0] headA, headB;
  logic headErrA, headErrB;

  assign s_ready  = (level_q != LW'(DEPTH));
  assign push     = s_valid && s_ready;
  assign pop      = (state_q == SEND_B);
  assign headA    = memA[rdPtr_q];
  assign headB    = memB[rdPtr_q];
  assign headErrA = memErrA[rdPtr_q];
  assign headErrB = memErrB[rdPtr_q];

  always_comb begin
    level_d = level_q + LW'(push) - LW'(pop);
  end

  // Storage needs no reset: entries are only read once level says they are live.
  always_ff @(posedge clk) begin
    if (push) begin
      memA[wrPtr_q]    <= s_a;
      memB[wrPtr_q]    <= s_b;
      memErrA[wrPtr_q] <= s_err_a;
      memErrB[wrPtr_q] <= s_err_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      level_q <= level_d;
      if (push) wrPtr_q <= wrPtr_q + PW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PW'(1);
    end
  end

  // The SEND_B exit edge is itself the first gap edge, so with GAP_CYCLES == 1
  // the FSM returns straight to IDLE and the next A can issue one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gapCnt_q    <= '0;
      pairsSent_q <= '0;
      dataOut_q   <= '0;
      parity_q    <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (level_q != '0 && !busy_in) begin
            dataOut_q <= headA;
            parity_q  <= (^headA) ^ headErrA;
            valid_q   <= 1'b1;
            state_q   <= SEND_A;
          end else begin
            valid_q <= 1'b0;
          end
        end
        SEND_A: begin
          dataOut_q <= headB;
          parity_q  <= (^headB) ^ headErrB;
          valid_q   <= 1'b1;
          state_q   <= SEND_B;
        end
        SEND_B: begin
          valid_q     <= 1'b0;
          pairsSent_q <= pairsSent_q + 16'd1;
          if (GAP_CYCLES <= 1) begin
            state_q <= IDLE;
          end else begin
            gapCnt_q <= GW'(GAP_CYCLES - 2);
            state_q  <= GAP;
          end
        end
        GAP: begin
          valid_q <= 1'b0;
          if (gapCnt_q == '0) state_q <= IDLE;
          else                gapCnt_q <= gapCnt_q - GW'(1);
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data_out        = dataOut_q;
  assign data_out_parity = parity_q;
  assign data_out_valid  = valid_q;
  assign level           = level_q;
  assign pairs_sent      = pairsSent_q;

endmodule

// File: tb/tb_fifomult_operand_feeder.sv
// Directed and randomised-order bench for fifomult_operand_feeder
// (DATA_W=16, DEPTH=4, GAP_CYCLES=1).
module tb_fifomult_operand_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_a = '0;
  logic [15:0] s_b = '0;
  logic        s_err_a = 1'b0;
  logic        s_err_b = 1'b0;
  logic        busy_in = 1'b0;
  logic [15:0] data_out;
  logic        data_out_parity;
  logic        data_out_valid;
  logic [2:0]  level;
  logic [15:0] pairs_sent;

  int total = 0;
  int bad = 0;
  int pairsExp = 0;

  fifomult_operand_feeder #(.DATA_W(16), .DEPTH(4), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_a(s_a), .s_b(s_b), .s_err_a(s_err_a), .s_err_b(s_err_b),
    .busy_in(busy_in), .data_out(data_out), .data_out_parity(data_out_parity),
    .data_out_valid(data_out_valid), .level(level), .pairs_sent(pairs_sent)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    total++; if (data_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid: got %b want 0", data_out_valid); end
    total++; if (level !== 3'd0) begin bad++; $display("[TB] FAIL rst_level: got %0d want 0", level); end
    total++; if (pairs_sent !== 16'd0) begin bad++; $display("[TB] FAIL rst_pairs: got %0d want 0", pairs_sent); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_ready: got %b want 1", s_ready); end
    rst = 1'b0;
    tick();
    s_valid = 1'b1; s_a = 16'h0001; s_b = 16'h0003;
    tick();
    s_valid = 1'b0;
    tick();
    total++; if (data_out_valid !== 1'b1 || data_out !== 16'h0001) begin bad++; $display("[TB] FAIL rst_pre_sendA: got v=%b d=%h want v=1 d=0001", data_out_valid, data_out); end
    #2 rst = 1'b1;
    #1;
    total++; if (data_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_valid: got %b want 0", data_out_valid); end
    total++; if (level !== 3'd0) begin bad++; $display("[TB] FAIL rst_mid_level: got %0d want 0", level); end
    total++; if (pairs_sent !== 16'd0) begin bad++; $display("[TB] FAIL rst_mid_pairs: got %0d want 0", pairs_sent); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_mid_ready: got %b want 1", s_ready); end
    #2 rst = 1'b0;
    tick();
    s_valid = 1'b1; s_a = 16'h0001; s_b = 16'h0003;
    tick();
    s_valid = 1'b0;
    tick();
    total++; if (data_out_valid !== 1'b1 || data_out !== 16'h0001 || data_out_parity !== 1'b1) begin bad++; $display("[TB] FAIL rst_after_A: got v=%b d=%h p=%b want v=1 d=0001 p=1", data_out_valid, data_out, data_out_parity); end
    tick();
    total++; if (data_out_valid !== 1'b1 || data_out !== 16'h0003 || data_out_parity !== 1'b0) begin bad++; $display("[TB] FAIL rst_after_B: got v=%b d=%h p=%b want v=1 d=0003 p=0", data_out_valid, data_out, data_out_parity); end
    tick();
    pairsExp = 1;
    total++; if (data_out_valid !== 1'b0 || pairs_sent !== 16'(pairsExp)) begin bad++; $display("[TB] FAIL rst_after_done: got v=%b n=%0d want v=0 n=%0d", data_out_valid, pairs_sent, pairsExp); end
  endtask

  task automatic test_single();
    s_valid = 1'b1; s_a = 16'h00F1; s_b = 16'h8000;
    tick();
    s_valid = 1'b0;
    total++; if (level !== 3'd1 || data_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_k: got lvl=%0d v=%b want lvl=1 v=0", level, data_out_valid); end
    tick();
    total++; if (data_out_valid !== 1'b1 || data_out !== 16'h00F1 || data_out_parity !== 1'b1) begin bad++; $display("[TB] FAIL single_A: got v=%b d=%h p=%b want v=1 d=00f1 p=1", data_out_valid, data_out, data_out_parity); end
    tick();
    total++; if (data_out_valid !== 1'b1 || data_out !== 16'h8000 || data_out_parity !== 1'b1) begin bad++; $display("[TB] FAIL single_B: got v=%b d=%h p=%b want v=1 d=8000 p=1", data_out_valid, data_out, data_out_parity); end
    tick();
    pairsExp++;
    total++; if (data_out_valid !== 1'b0 || pairs_sent !== 16'(pairsExp) || level !== 3'd0) begin bad++; $display("[TB] FAIL single_done: got v=%b n=%0d lvl=%0d want v=0 n=%0d lvl=0", data_out_valid, pairs_sent, level, pairsExp); end
  endtask

  task automatic test_error();
    s_valid = 1'b1; s_a = 16'h0000; s_b = 16'hFFFF; s_err_a = 1'b1; s_err_b = 1'b0;
    tick();
    s_valid = 1'b0; s_err_a = 1'b0;
    tick();
    total++; if (data_out !== 16'h0000 || data_out_parity !== 1'b1) begin bad++; $display("[TB] FAIL err_A: got d=%h p=%b want d=0000 p=1", data_out, data_out_parity); end
    tick();
    total++; if (data_out !== 16'hFFFF || data_out_parity !== 1'b0) begin bad++; $display("[TB] FAIL err_B: got d=%h p=%b want d=ffff p=0", data_out, data_out_parity); end
    tick();
    pairsExp++;
  endtask

  task automatic test_full();
    logic [15:0] expW [10];
    int idx;
    for (int i = 0; i < 5; i++) begin
      expW[2*i]   = 16'h1000 + 16'(i * 3);
      expW[2*i+1] = 16'h2000 + 16'(i * 5);
    end
    busy_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_a = expW[2*i]; s_b = expW[2*i+1];
      total++; if (s_ready !== 1'b1) begin bad++; $display("[TB] FAIL full_ready_%0d: got %b want 1", i, s_ready); end
      tick();
    end
    s_a = expW[8]; s_b = expW[9];
    total++; if (level !== 3'd4 || s_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_level: got lvl=%0d rdy=%b want lvl=4 rdy=0", level, s_ready); end
    tick(); tick();
    total++; if (level !== 3'd4 || data_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL full_stall: got lvl=%0d v=%b want lvl=4 v=0", level, data_out_valid); end
    busy_in = 1'b0;
    idx = 0;
    for (int c = 0; c < 40 && idx < 10; c++) begin
      tick();
      if (c == 2) begin
        total++; if (level !== 3'd3 || s_ready !== 1'b1) begin bad++; $display("[TB] FAIL full_first_pop: got lvl=%0d rdy=%b want lvl=3 rdy=1", level, s_ready); end
      end
      if (c == 3) begin
        total++; if (level !== 3'd4 || s_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_fifth_push: got lvl=%0d rdy=%b want lvl=4 rdy=0", level, s_ready); end
        s_valid = 1'b0;
      end
      if (data_out_valid) begin
        total++; if (data_out !== expW[idx] || data_out_parity !== ^expW[idx]) begin bad++; $display("[TB] FAIL full_word_%0d: got d=%h p=%b want d=%h p=%b", idx, data_out, data_out_parity, expW[idx], ^expW[idx]); end
        if (idx % 2 == 0) begin
          total++; if (c !== 3 * (idx / 2)) begin bad++; $display("[TB] FAIL full_spacing_%0d: got cycle %0d want %0d", idx, c, 3 * (idx / 2)); end
        end
        idx++;
      end
    end
    total++; if (idx !== 10) begin bad++; $display("[TB] FAIL full_timeout: got %0d words want 10", idx); end
    tick();
    pairsExp += 5;
    total++; if (pairs_sent !== 16'(pairsExp) || level !== 3'd0) begin bad++; $display("[TB] FAIL full_done: got n=%0d lvl=%0d want n=%0d lvl=0", pairs_sent, level, pairsExp); end
  endtask

  task automatic test_busy_mid();
    logic stalledOk;
    s_valid = 1'b1; s_a = 16'h1234; s_b = 16'h5678;
    tick();
    s_a = 16'h9ABC; s_b = 16'hDEF0;
    tick();
    s_valid = 1'b0;
    busy_in = 1'b1;
    total++; if (data_out_valid !== 1'b1 || data_out !== 16'h1234) begin bad++; $display("[TB] FAIL busy_A: got v=%b d=%h want v=1 d=1234", data_out_valid, data_out); end
    tick();
    total++; if (data_out_valid !== 1'b1 || data_out !== 16'h5678) begin bad++; $display("[TB] FAIL busy_B: got v=%b d=%h want v=1 d=5678", data_out_valid, data_out); end
    tick();
    total++; if (data_out_valid !== 1'b0 || level !== 3'd1) begin bad++; $display("[TB] FAIL busy_pop: got v=%b lvl=%0d want v=0 lvl=1", data_out_valid, level); end
    stalledOk = 1'b1;
    repeat (4) begin
      tick();
      if (data_out_valid !== 1'b0) stalledOk = 1'b0;
    end
    total++; if (stalledOk !== 1'b1) begin bad++; $display("[TB] FAIL busy_hold: got issue while busy, want none"); end
    busy_in = 1'b0;
    tick();
    total++; if (data_out_valid !== 1'b1 || data_out !== 16'h9ABC) begin bad++; $display("[TB] FAIL busy_resume_A: got v=%b d=%h want v=1 d=9abc", data_out_valid, data_out); end
    tick();
    total++; if (data_out_valid !== 1'b1 || data_out !== 16'hDEF0) begin bad++; $display("[TB] FAIL busy_resume_B: got v=%b d=%h want v=1 d=def0", data_out_valid, data_out); end
    tick();
    pairsExp += 2;
    total++; if (pairs_sent !== 16'(pairsExp)) begin bad++; $display("[TB] FAIL busy_pairs: got %0d want %0d", pairs_sent, pairsExp); end
  endtask

  task automatic test_wrap();
    logic [15:0] q [$];
    logic [15:0] expWord;
    logic acc;
    int sent, rcvd;
    sent = 0; rcvd = 0;
    for (int cyc = 0; cyc < 3000 && rcvd < 40; cyc++) begin
      if (!s_valid && sent < 20 && $urandom_range(0, 3) != 0) begin
        s_valid = 1'b1;
        s_a = 16'($urandom);
        s_b = 16'($urandom);
      end
      busy_in = ($urandom_range(0, 3) == 0);
      acc = s_valid && s_ready;
      tick();
      if (acc) begin
        q.push_back(s_a);
        q.push_back(s_b);
        sent++;
        s_valid = 1'b0;
      end
      if (data_out_valid) begin
        if (q.size() == 0) begin
          total++; bad++; $display("[TB] FAIL wrap_extra: got unexpected word %h", data_out);
        end else begin
          expWord = q.pop_front();
          total++; if (data_out !== expWord) begin bad++; $display("[TB] FAIL wrap_word_%0d: got %h want %h", rcvd, data_out, expWord); end
          total++; if ((^{data_out, data_out_parity}) !== 1'b0) begin bad++; $display("[TB] FAIL wrap_parity_%0d: got p=%b for d=%h want even", rcvd, data_out_parity, data_out); end
        end
        rcvd++;
      end
    end
    busy_in = 1'b0;
    s_valid = 1'b0;
    repeat (3) tick();
    pairsExp += 20;
    total++; if (rcvd !== 40) begin bad++; $display("[TB] FAIL wrap_timeout: got %0d words want 40", rcvd); end
    total++; if (pairs_sent !== 16'(pairsExp) || level !== 3'd0) begin bad++; $display("[TB] FAIL wrap_done: got n=%0d lvl=%0d want n=%0d lvl=0", pairs_sent, level, pairsExp); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_error();
    test_full();
    test_busy_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish want finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
